// File: rtl/reloj_pkg.sv
// Shared definitions for the time-of-day counter: FSM state encoding,
// BCD digit limits and the two-digit BCD increment helpers.
package reloj_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10
    } estado_t;

    localparam logic [3:0] MAX_MIN_TENS    = 4'd5;
    localparam logic [3:0] MAX_MIN_UNITS   = 4'd9;
    localparam logic [3:0] MAX_HOUR_TENS   = 4'd2;
    localparam logic [3:0] HOUR_WRAP_UNITS = 4'd3;
    localparam logic [3:0] MAX_BCD_UNITS   = 4'd9;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd2_t;

    function automatic logic is_min_wrap(input bcd2_t m);
        return (m.tens == MAX_MIN_TENS) && (m.units == MAX_MIN_UNITS);
    endfunction

    function automatic logic is_hour_wrap(input bcd2_t h);
        return (h.tens == MAX_HOUR_TENS) && (h.units == HOUR_WRAP_UNITS);
    endfunction

    // 59 wraps to 00; the caller decides whether that carries into hours.
    function automatic bcd2_t inc_min(input bcd2_t m);
        bcd2_t r;
        r = m;
        if (m.units == MAX_MIN_UNITS) begin
            r.units = 4'd0;
            r.tens  = (m.tens == MAX_MIN_TENS) ? 4'd0 : m.tens + 4'd1;
        end else begin
            r.units = m.units + 4'd1;
        end
        return r;
    endfunction

    // 23 wraps to 00; otherwise a plain BCD increment of the units digit.
    function automatic bcd2_t inc_hour(input bcd2_t h);
        bcd2_t r;
        r = h;
        if (is_hour_wrap(h)) begin
            r.tens  = 4'd0;
            r.units = 4'd0;
        end else if (h.units == MAX_BCD_UNITS) begin
            r.units = 4'd0;
            r.tens  = h.tens + 4'd1;
        end else begin
            r.units = h.units + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// Single-bit rising-edge detector. History resets to 1 so an input that is
// already high when reset is released does not look like a fresh edge.
module detector_flanco (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev <= 1'b1;
        end else begin
            prev <= din;
        end
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/contador_hora_minuto.sv
// 24-hour HH:MM counter in BCD driven by the minute divider, with a
// three-state mode machine for setting hours and minutes by button.
module contador_hora_minuto
    import reloj_pkg::*;
#(
    parameter int unsigned EDGES_PER_MIN = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick_in,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] min_units,
    output logic [3:0] min_tens,
    output logic [3:0] hour_units,
    output logic [3:0] hour_tens,
    output logic [1:0] setting,
    output logic       day_tick
);

    localparam logic [7:0] PRE_LAST = 8'(EDGES_PER_MIN - 1);

    logic tick_rise;
    logic mode_rise;
    logic inc_rise;

    estado_t state;
    estado_t state_next;

    bcd2_t      min_q;
    bcd2_t      hour_q;
    logic [7:0] pre_q;
    logic       day_q;

    bcd2_t      min_next;
    bcd2_t      hour_next;
    logic [7:0] pre_next;
    logic       day_next;

    detector_flanco u_det_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (tick_in),
        .rise    (tick_rise)
    );

    detector_flanco u_det_mode (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (btn_mode),
        .rise    (mode_rise)
    );

    detector_flanco u_det_inc (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (btn_inc),
        .rise    (inc_rise)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (mode_rise) begin
            case (state)
                ST_RUN:      state_next = ST_SET_HOUR;
                ST_SET_HOUR: state_next = ST_SET_MIN;
                ST_SET_MIN:  state_next = ST_RUN;
                default:     state_next = ST_RUN;
            endcase
        end
    end

    // Time updates key off the current state, so a tick in the cycle RUN is
    // left still counts, and one in the cycle RUN is re-entered does not.
    always_comb begin
        min_next  = min_q;
        hour_next = hour_q;
        pre_next  = pre_q;
        day_next  = 1'b0;
        case (state)
            ST_RUN: begin
                if (tick_rise) begin
                    if (pre_q == PRE_LAST) begin
                        pre_next = 8'd0;
                        min_next = inc_min(min_q);
                        if (is_min_wrap(min_q)) begin
                            hour_next = inc_hour(hour_q);
                            day_next  = is_hour_wrap(hour_q);
                        end
                    end else begin
                        pre_next = pre_q + 8'd1;
                    end
                end
            end
            ST_SET_HOUR: begin
                if (inc_rise && !mode_rise) begin
                    hour_next = inc_hour(hour_q);
                end
            end
            ST_SET_MIN: begin
                if (inc_rise && !mode_rise) begin
                    min_next = inc_min(min_q);
                end
                if (mode_rise) begin
                    pre_next = 8'd0;
                end
            end
            default: begin
                pre_next = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            min_q  <= '0;
            hour_q <= '0;
            pre_q  <= 8'd0;
            day_q  <= 1'b0;
        end else begin
            min_q  <= min_next;
            hour_q <= hour_next;
            pre_q  <= pre_next;
            day_q  <= day_next;
        end
    end

    assign min_units  = min_q.units;
    assign min_tens   = min_q.tens;
    assign hour_units = hour_q.units;
    assign hour_tens  = hour_q.tens;
    assign setting    = state;
    assign day_tick   = day_q;

endmodule

// File: tb/tb_contador_hora_minuto.sv
// Self-checking bench: one counter with a one-edge prescaler and one with a
// four-edge prescaler, each compared against hand-derived HH:MM values.
module tb_contador_hora_minuto;

    logic       clock;
    logic       reset_n;
    logic [1:0] tick_v;
    logic [1:0] mode_v;
    logic [1:0] inc_v;

    logic [3:0] mu_a, mt_a, hu_a, ht_a, mu_b, mt_b, hu_b, ht_b;
    logic [1:0] set_a, set_b;
    logic       day_a, day_b;

    int compared;
    int mismatched;

    typedef struct {
        string       tag;
        logic [18:0] val;
    } exp_t;

    exp_t sb[$];

    contador_hora_minuto #(.EDGES_PER_MIN(1)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .tick_in    (tick_v[0]),
        .btn_mode   (mode_v[0]),
        .btn_inc    (inc_v[0]),
        .min_units  (mu_a),
        .min_tens   (mt_a),
        .hour_units (hu_a),
        .hour_tens  (ht_a),
        .setting    (set_a),
        .day_tick   (day_a)
    );

    contador_hora_minuto #(.EDGES_PER_MIN(4)) dut4 (
        .clock      (clock),
        .reset_n    (reset_n),
        .tick_in    (tick_v[1]),
        .btn_mode   (mode_v[1]),
        .btn_inc    (inc_v[1]),
        .min_units  (mu_b),
        .min_tens   (mt_b),
        .hour_units (hu_b),
        .hour_tens  (ht_b),
        .setting    (set_b),
        .day_tick   (day_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [18:0] mk(input int st, input int day, input int hh, input int mm);
        return {2'(st), 1'(day), 4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
    endfunction

    function automatic logic [18:0] observe(input int d);
        if (d == 0) return {set_a, day_a, ht_a, hu_a, mt_a, mu_a};
        return {set_b, day_b, ht_b, hu_b, mt_b, mu_b};
    endfunction

    task automatic checkOutput(input string tag, input logic [18:0] observed, input logic [18:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got set/day/HHMM=%b/%b/%h required %b/%b/%h", tag,
                     observed[18:17], observed[16], observed[15:0],
                     expected[18:17], expected[16], expected[15:0]);
        end
    endtask

    task automatic pulse(input int d, input logic t, input logic m, input logic i);
        @(negedge clock);
        tick_v[d] = t;
        mode_v[d] = m;
        inc_v[d]  = i;
        @(negedge clock);
        tick_v[d] = 1'b0;
        mode_v[d] = 1'b0;
        inc_v[d]  = 1'b0;
    endtask

    task automatic popCheck(input int d);
        exp_t e;
        e = sb.pop_front();
        checkOutput(e.tag, observe(d), e.val);
    endtask

    task automatic applyStimulus(input int d, input logic t, input logic m, input logic i,
                                 input string tag, input logic [18:0] exp);
        sb.push_back('{tag, exp});
        pulse(d, t, m, i);
        popCheck(d);
    endtask

    task automatic expectIdle(input int d, input string tag, input logic [18:0] exp);
        sb.push_back('{tag, exp});
        @(negedge clock);
        popCheck(d);
    endtask

    task automatic pressN(input int d, input logic t, input logic m, input logic i, input int n);
        for (int k = 0; k < n; k++) pulse(d, t, m, i);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_n    = 1'b0;
        tick_v     = 2'b11;
        mode_v     = 2'b00;
        inc_v      = 2'b00;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Tick held high across reset release must not count.
        expectIdle(0, "release_high_tick", mk(0, 0, 0, 0));
        expectIdle(1, "release_high_tick4", mk(0, 0, 0, 0));
        tick_v = 2'b00;
        expectIdle(0, "tick_low_idle", mk(0, 0, 0, 0));
        applyStimulus(0, 1, 0, 0, "tick1", mk(0, 0, 0, 1));
        applyStimulus(0, 1, 0, 0, "tick2", mk(0, 0, 0, 2));
        applyStimulus(0, 1, 0, 0, "tick3", mk(0, 0, 0, 3));

        // Preload 09:59, then hour-tens carry.
        applyStimulus(0, 0, 1, 0, "to_set_hour", mk(1, 0, 0, 3));
        pressN(0, 0, 0, 1, 8);
        applyStimulus(0, 0, 0, 1, "hour_09", mk(1, 0, 9, 3));
        applyStimulus(0, 0, 1, 0, "to_set_min", mk(2, 0, 9, 3));
        pressN(0, 0, 0, 1, 55);
        applyStimulus(0, 0, 0, 1, "min_59", mk(2, 0, 9, 59));
        applyStimulus(0, 1, 0, 0, "tick_in_set_min", mk(2, 0, 9, 59));
        applyStimulus(0, 0, 1, 0, "back_to_run", mk(0, 0, 9, 59));
        applyStimulus(0, 1, 0, 0, "0959_to_1000", mk(0, 0, 10, 0));

        pulse(0, 0, 1, 0);
        pressN(0, 0, 0, 1, 9);
        pulse(0, 0, 1, 0);
        pressN(0, 0, 0, 1, 59);
        pulse(0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, "1959_to_2000", mk(0, 0, 20, 0));

        // Preload 23:58 and roll over the day.
        pulse(0, 0, 1, 0);
        pressN(0, 0, 0, 1, 3);
        pulse(0, 0, 1, 0);
        pressN(0, 0, 0, 1, 58);
        pulse(0, 0, 1, 0);
        expectIdle(0, "preload_2358", mk(0, 0, 23, 58));
        applyStimulus(0, 1, 0, 0, "2358_to_2359", mk(0, 0, 23, 59));
        applyStimulus(0, 1, 0, 0, "day_rollover", mk(0, 1, 0, 0));
        expectIdle(0, "day_tick_one_cycle", mk(0, 0, 0, 0));

        // Set-mode wraps carry nothing and raise no day_tick.
        applyStimulus(0, 0, 1, 0, "set_hour_again", mk(1, 0, 0, 0));
        pressN(0, 0, 0, 1, 23);
        applyStimulus(0, 0, 0, 1, "hour_wrap_no_day", mk(1, 0, 0, 0));
        applyStimulus(0, 0, 0, 1, "hour_25th", mk(1, 0, 1, 0));
        applyStimulus(0, 1, 0, 0, "tick_in_set_hour", mk(1, 0, 1, 0));
        applyStimulus(0, 0, 1, 0, "set_min_again", mk(2, 0, 1, 0));
        pressN(0, 0, 0, 1, 59);
        applyStimulus(0, 0, 0, 1, "min_wrap_no_carry", mk(2, 0, 1, 0));
        applyStimulus(0, 0, 0, 1, "min_61st", mk(2, 0, 1, 1));
        applyStimulus(0, 0, 1, 0, "run_0101", mk(0, 0, 1, 1));

        // Simultaneous events.
        applyStimulus(0, 0, 0, 1, "inc_ignored_run", mk(0, 0, 1, 1));
        applyStimulus(0, 1, 1, 0, "tick_on_run_exit", mk(1, 0, 1, 2));
        applyStimulus(0, 0, 1, 1, "mode_beats_inc", mk(2, 0, 1, 2));
        applyStimulus(0, 1, 1, 0, "tick_on_run_entry", mk(0, 0, 1, 2));

        // Preload 14:37 and reset asynchronously mid-cycle.
        pulse(0, 0, 1, 0);
        pressN(0, 0, 0, 1, 13);
        pulse(0, 0, 1, 0);
        pressN(0, 0, 0, 1, 35);
        applyStimulus(0, 0, 1, 0, "run_1437", mk(0, 0, 14, 37));
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        sb.push_back('{"async_reset", mk(0, 0, 0, 0)});
        popCheck(0);
        @(negedge clock);
        reset_n = 1'b1;
        expectIdle(0, "after_reset", mk(0, 0, 0, 0));

        // Four edges per minute, and prescaler clear on return to RUN.
        pressN(1, 1, 0, 0, 2);
        applyStimulus(1, 1, 0, 0, "pre4_tick3", mk(0, 0, 0, 0));
        applyStimulus(1, 1, 0, 0, "pre4_tick4", mk(0, 0, 0, 1));
        pressN(1, 1, 0, 0, 2);
        applyStimulus(1, 0, 1, 0, "pre4_set_hour", mk(1, 0, 0, 1));
        applyStimulus(1, 0, 1, 0, "pre4_set_min", mk(2, 0, 0, 1));
        applyStimulus(1, 0, 1, 0, "pre4_run", mk(0, 0, 0, 1));
        pressN(1, 1, 0, 0, 2);
        applyStimulus(1, 1, 0, 0, "pre4_cleared_3", mk(0, 0, 0, 1));
        applyStimulus(1, 1, 0, 0, "pre4_cleared_4", mk(0, 0, 0, 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
